// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - run/stop and glitch-free reprogramming controller for the programmable clock divider
module clk_div_ctrl #(
    parameter int unsigned DIVIDE_FACTOR = 20,
    parameter int unsigned WIDTH         = 16
) (
    input  logic             I_CLK,
    input  logic             Rst,
    input  logic             I_EN,
    input  logic             I_LOAD,
    input  logic [WIDTH-1:0] I_DIV,
    output logic             O_CLK,
    output logic             O_TICK,
    output logic             O_ACK,
    output logic             O_ERR,
    output logic             O_BUSY,
    output logic [WIDTH-1:0] O_CUR_DIV
);

    localparam logic [WIDTH-1:0] LP_DEF = WIDTH'(DIVIDE_FACTOR);
    localparam logic [WIDTH-1:0] LP_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] LP_TWO = WIDTH'(2);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_cur_div;
    logic [WIDTH-1:0] w_cur_nxt;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] w_shadow_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_clk;
    logic             w_clk_nxt;
    logic             r_tick;
    logic             w_tick_nxt;
    logic             r_ack;
    logic             w_ack_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             w_boundary;
    logic             w_accept;

    assign w_boundary = (r_cnt == (r_cur_div - LP_ONE));
    assign w_accept   = I_LOAD && !r_busy;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_cur_nxt    = r_cur_div;
        w_shadow_nxt = r_shadow;
        w_busy_nxt   = r_busy;
        w_ack_nxt    = 1'b0;
        w_err_nxt    = 1'b0;

        case (r_state)
            ST_STOP: begin
                w_cnt_nxt = '0;
                if (I_EN) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                // A pending factor only ever takes effect here, so no period is cut short.
                if (w_boundary) begin
                    w_cnt_nxt = '0;
                    if (r_busy) begin
                        w_cur_nxt  = r_shadow;
                        w_busy_nxt = 1'b0;
                        w_ack_nxt  = 1'b1;
                    end
                    w_state_nxt = I_EN ? ST_RUN : ST_STOP;
                end else begin
                    w_cnt_nxt   = r_cnt + LP_ONE;
                    w_state_nxt = I_EN ? ST_RUN : ST_DRAIN;
                end
            end
        endcase

        if (w_accept) begin
            if (I_DIV < LP_TWO) begin
                w_err_nxt = 1'b1;
            end else if (r_state == ST_STOP) begin
                w_cur_nxt = I_DIV;
                w_ack_nxt = 1'b1;
            end else begin
                w_shadow_nxt = I_DIV;
                w_busy_nxt   = 1'b1;
            end
        end

        // Outputs are registered against the next count so they line up with r_cnt.
        w_clk_nxt  = (w_state_nxt != ST_STOP) && (w_cnt_nxt < (w_cur_nxt >> 1));
        w_tick_nxt = (w_state_nxt != ST_STOP) && (w_cnt_nxt == '0);
    end

    always_ff @(posedge I_CLK or negedge Rst) begin
        if (!Rst) begin
            r_state   <= ST_STOP;
            r_cnt     <= '0;
            r_cur_div <= LP_DEF;
            r_shadow  <= '0;
            r_busy    <= 1'b0;
            r_clk     <= 1'b0;
            r_tick    <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cur_div <= w_cur_nxt;
            r_shadow  <= w_shadow_nxt;
            r_busy    <= w_busy_nxt;
            r_clk     <= w_clk_nxt;
            r_tick    <= w_tick_nxt;
            r_ack     <= w_ack_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign O_CLK     = r_clk;
    assign O_TICK    = r_tick;
    assign O_ACK     = r_ack;
    assign O_ERR     = r_err;
    assign O_BUSY    = r_busy;
    assign O_CUR_DIV = r_cur_div;

endmodule
